truth_table_reader: RTL

- Characterisation master for the 4-input combinational logic circuits in this library.
- Drives the circuit's inputs in1..in4 through all 16 vectors and waits a programmable settle time per vector.
- Samples the circuit output and assembles the 16-bit truth-table word in the library's hex convention (e.g. 0x1FDE).
- Compares the word against an expected value and reports match. It is the stimulus/capture end of the circuit's input/output interface.

---
 rtl/tt_pkg.sv | 24 ++
 rtl/tt_sync.sv | 36 +++
 rtl/truth_table_reader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table characterisation master.
//   state_e        : controller states (IDLE, SETTLE, SAMPLE)
//   N_IN, N_VEC    : number of circuit inputs and number of input vectors
//   vec_to_inputs  : maps a vector index to {in1,in2,in3,in4}, in1 the MSB
//   TT_0x1FDE      : reference truth table of the library's ordering example
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_e;

    localparam int N_IN  = 4;
    localparam int N_VEC = 16;

    localparam logic [15:0] TT_0x1FDE = 16'h1FDE;

    // The vector index is applied directly, so idx bit 3 drives in1.
    function automatic logic [N_IN-1:0] vec_to_inputs(input logic [N_IN-1:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/tt_sync.sv
// Synchroniser for the characterised circuit's output.
//   clk, rst_n : clock and asynchronous active-low reset
//   d_i        : raw circuit output
//   q_o        : value after STAGES flops (combinational pass-through when STAGES is 0)
module tt_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;

            // Shift chain: stage 0 takes the raw input, each later stage the one before.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d_i;
                    for (int i = 1; i < STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign q_o = sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/truth_table_reader.sv
// Characterisation master for 4-input combinational circuits.
// Steps in1..in4 through vectors 0..15, holds each for SETTLE_CYCLES clocks,
// samples the (synchronised) circuit output and assembles the 16-bit truth
// table with the vector-0 sample as the MSB, then compares it to 'expected'.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : run request (IDLE only) / cancel a run in progress
//   expected[15:0]      : reference table, captured when a run is accepted
//   in1..in4            : registered drives to the circuit under test
//   dut_out             : circuit output
//   busy, done          : run in progress / one-clock completion pulse
//   result[15:0]        : assembled truth table
//   result_valid, match : result is from a complete run / result == expected
// SETTLE_CYCLES must be at least SYNC_STAGES+1 so the sampled value belongs
// to the vector currently driven.
module truth_table_reader
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    input  logic        dut_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        match
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_IDX    = 4'(N_VEC - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  drv_q, drv_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] result_q, result_d;
    logic        valid_q, valid_d;
    logic        match_q, match_d;
    logic [15:0] exp_q, exp_d;

    logic        dut_sync_s;
    logic [15:0] shifted_s;

    tt_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dut_out),
        .q_o   (dut_sync_s)
    );

    // The new sample enters at bit 0, so the first vector ends up as bit 15.
    assign shifted_s = {result_q[14:0], dut_sync_s};

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        drv_d    = drv_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        valid_d  = valid_q;
        match_d  = match_q;
        exp_d    = exp_q;

        case (state_q)
            IDLE: begin
                // abort outranks start so a simultaneous request is refused
                if (start && !abort) begin
                    state_d  = SETTLE;
                    idx_d    = 4'd0;
                    cnt_d    = 8'd0;
                    drv_d    = vec_to_inputs(4'd0);
                    busy_d   = 1'b1;
                    result_d = 16'h0000;
                    valid_d  = 1'b0;
                    match_d  = 1'b0;
                    exp_d    = expected;
                end else begin
                    state_d = IDLE;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    drv_d   = 4'd0;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    match_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = SAMPLE;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end

            SAMPLE: begin
                // an abort on the sample edge discards the sample: result stays as-is
                if (abort) begin
                    state_d = IDLE;
                    drv_d   = 4'd0;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    match_d = 1'b0;
                end else begin
                    result_d = shifted_s;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        drv_d   = 4'd0;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        match_d = (shifted_s == exp_q);
                    end else begin
                        state_d = SETTLE;
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = 8'd0;
                        drv_d   = vec_to_inputs(idx_q + 4'd1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                drv_d   = 4'd0;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                match_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            cnt_q    <= 8'd0;
            drv_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 16'h0000;
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
            exp_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            drv_q    <= drv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            exp_q    <= exp_d;
        end
    end

    assign in1          = drv_q[3];
    assign in2          = drv_q[2];
    assign in3          = drv_q[1];
    assign in4          = drv_q[0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign match        = match_q;

endmodule
